// File: rtl/bcd_pkg.sv
// Shared widths, step count, FSM state type and digit-check helper for bcd_to_bin.
package bcd_pkg;

    localparam int BCD_DIGITS = 10;
    localparam int BCD_W      = 40;
    localparam int BIN_W      = 36;
    localparam int CONV_STEPS = 36;
    localparam int CNT_W      = 6;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(CONV_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when any nibble of a packed BCD word is outside 0..9.
    function automatic logic bcd_has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One digit of the reverse double-dabble correction: subtract 3 when the digit is 8 or more.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd8) ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Serial 10-digit BCD to 36-bit binary converter (reverse double-dabble, one bit per cycle).
// Optional macro BCD_TO_BIN_DIGIT_CHECK_EN flags operands containing digits above 9.
module bcd_to_bin
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BIN_W-1:0] binary,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic [BIN_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [BCD_W+BIN_W-1:0] shift_w;
    logic [BCD_W-1:0]       adj_w;

    // Digit bit 0 falls into result bit 35 on every step.
    assign shift_w = {digits_q, result_q} >> 1;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (shift_w[BIN_W + 4*g +: 4]),
            .d_o (adj_w[4*g +: 4])
        );
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    digits_d = bcd_in;
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_CONV;
                end
            end
            ST_CONV: begin
                digits_d = adj_w;
                result_d = shift_w[BIN_W-1:0];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && in_valid) err_d = bcd_has_bad_digit(bcd_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    // The conversion still runs on a bad operand so latency is unchanged; only the output is masked.
    assign err    = err_q & out_valid;
    assign binary = err_q ? '0 : result_q;
`else
    assign err    = 1'b0;
    assign binary = result_q;
`endif

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from the shared package (BCD_DIGITS=10, BCD_W=40, BIN_W=36).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 bcd_in  input  40  ten packed BCD digits; [3:0]=ones, [7:4]=tens, ... [39:36]=billions.
REQ-005 in_valid  input  1  bcd_in is valid.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 binary  output  36  unsigned binary result.
REQ-008 out_valid  output  1  binary and err are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 err  output  1  invalid-digit flag (see Configuration).

Function
REQ-011 The block SHALL have states IDLE, CONV and DONE.
REQ-012 In IDLE, in_ready SHALL be 1. In CONV and DONE, in_ready SHALL be 0.
REQ-013 The accept condition SHALL be in_valid && in_ready at a clock edge.
- On accept: load bcd_in into a 40-bit digit register, clear the 36-bit result register, clear the 6-bit shift counter, go to CONV.
REQ-014 Each CONV cycle SHALL perform one reverse double-dabble step:
- shift {digits,result} right by 1 (digit bit 0 enters result bit 35);
- then subtract 3 from every 4-bit digit whose value is >= 8.
REQ-015 CONV SHALL run exactly 36 steps.
- After the 36th step's edge the state SHALL be DONE.
- out_valid SHALL rise exactly 36 cycles after the accept edge.
REQ-016 In DONE, out_valid SHALL be 1. binary and err SHALL hold stable until out_valid && out_ready.
REQ-017 On out_valid && out_ready the block SHALL return to IDLE on that edge.
- No operand SHALL be accepted in the same cycle.
- Minimum issue interval SHALL therefore be 38 cycles.
REQ-018 binary SHALL equal the decimal value of bcd_in for all valid inputs.
- Maximum input 9,999,999,999 = 36'h2540BE3FF fits in 36 bits, so no overflow is possible.
REQ-019 in_valid SHALL be ignored outside IDLE. bcd_in changes during CONV SHALL NOT affect the result.
REQ-020 out_ready SHALL be ignored outside DONE.

Reset
REQ-021 While rst is high, the block SHALL be in IDLE with out_valid=0, binary=0, err=0, in_ready=1, counter=0.
REQ-022 Reset asserted mid-CONV or in DONE SHALL abort the conversion. The pending result SHALL be discarded and SHALL never be presented.
REQ-023 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-024 Macro BCD_TO_BIN_DIGIT_CHECK_EN, when defined, SHALL enable the invalid-digit check:
- on accept, any bcd_in digit > 9 SHALL set err;
- in DONE, err SHALL be 1 and binary SHALL be forced to 0;
- latency SHALL be unchanged.
REQ-025 Without BCD_TO_BIN_DIGIT_CHECK_EN:
- err SHALL be constant 0;
- digits > 9 SHALL be converted by the same algorithm with no special handling (value unspecified, deterministic).

Structure
REQ-026 Package bcd_pkg SHALL hold BCD_DIGITS, BCD_W, BIN_W, the step count constant (36) and the state enum type.
REQ-027 Sub-module bcd_digit_adj (combinational, 4-bit in/out, subtract 3 when >= 8) SHALL be instantiated once per digit.

Verification
REQ-028 Reset, then accept bcd_in=40'h0 -> out_valid exactly 36 cycles later, binary=0, err=0.
REQ-029 Accept bcd_in=40'h0000001234 -> binary=36'h4D2. Accept 40'h9999999999 -> binary=36'h2540BE3FF.
REQ-030 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with a new operand:
- binary stays stable and in_ready stays 0;
- after out_ready=1, the block returns to IDLE, then accepts the new operand.
REQ-031 Assert rst 20 cycles into a conversion of 40'h0000000042:
- out_valid=0 immediately;
- the next conversion of 40'h0000000007 returns binary=7 with no stale result.
REQ-032 With BCD_TO_BIN_DIGIT_CHECK_EN, accept bcd_in=40'h000000000A -> err=1, binary=0. Without it -> err=0.
REQ-033 Randomised back-to-back stream of 1000 valid operands with random out_ready -> every result matches a reference decimal model, in order, none dropped.
